az_sequencer: RTL and testbench

- Timed auto-zero sequencer for the DMM input conditioning path. It drives the 14-bit conditioning vector {led0, sig_pc_sw_ctl, himux2[3:0], himux[3:0], azmux[3:0]}, which top feeds into one input of the conditioning mux_4to1_assign.
- It alternates between the signal phase and the zero (LO) phase, using programmable settle and measure windows.
- For each window it flags the ADC and raises an interrupt once per completed cycle.

---
 rtl/dmm_defs.sv | 49 ++++
 rtl/phase_timer.sv | 35 +++
 rtl/az_sequencer.sv | 174 +++++++++++++++++
 tb/tb_az_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmm_defs.sv
// dmm_defs - shared definitions for the DMM input-conditioning path.
//
// Contents:
//   - bit positions of the 14-bit conditioning vector
//     {led0, pc, himux2[3:0], himux[3:0], azmux[3:0]}
//   - analog mux code constants
//   - sequencer mode encodings and FSM state type
package dmm_defs;

  // Width of the conditioning vector. The field layout below is fixed.
  localparam int COND_BITS  = 14;

  // Bit positions of the fields inside the conditioning vector.
  localparam int MUX_W      = 4;
  localparam int AZMUX_LSB  = 0;
  localparam int HIMUX_LSB  = 4;
  localparam int HIMUX2_LSB = 8;
  localparam int PC_BIT     = 12;
  localparam int LED_BIT    = 13;

  // Mux codes. Bit 3 is the mux enable, so MUX_OFF disables the mux.
  localparam logic [3:0] MUX_OFF = 4'b0000;
  localparam logic [3:0] MUX_S1  = 4'b1000;
  localparam logic [3:0] MUX_S2  = 4'b1001;
  localparam logic [3:0] MUX_S4  = 4'b1011;

  // Sequencer modes. MODE_RSVD behaves exactly like MODE_OFF.
  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_SIG  = 2'd1,
    MODE_AZ   = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // Auto-zero sequencer states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTLE_HI = 3'd1,
    MEAS_HI   = 3'd2,
    SETTLE_LO = 3'd3,
    MEAS_LO   = 3'd4
  } state_e;

  // True for the modes that actually run a sequence.
  function automatic logic mode_runs(input logic [1:0] m);
    return (m == MODE_SIG) || (m == MODE_AZ);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer - loadable down-counter used to time the sequencer phases.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high
//   load     in   load load_val this clock (takes priority over counting)
//   load_val in   CNT_W value loaded into the counter
//   count    out  CNT_W current counter value
//   done     out  high while count is zero
module phase_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  // Counts down to zero and parks there; it never wraps, so a phase can
  // only end by the owner loading a new length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/az_sequencer.sv
// az_sequencer - timed auto-zero sequencer for the DMM input conditioning.
//
// Alternates the front end between the signal (HI) and zero (LO) inputs with
// programmable settle and measure windows, flags each measure window to the
// ADC and raises a sticky interrupt once per completed cycle.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   enable              run the sequence; low forces IDLE
//   mode[1:0]           0 off, 1 signal only, 2 two-phase AZ, 3 as 0
//   azmux_sig/azmux_lo  azmux codes for the HI / LO phases
//   himux_cfg           himux code for the active phases
//   himux2_cfg          himux2 code for the active phases
//   t_settle, t_meas    settle / measure lengths in clocks (0 acts as 1)
//   irq_clear           one-clock pulse clearing irq and overrun
//   conditioning_out    registered {led0, pc, himux2, himux, azmux}
//   adc_window          high during the measure states
//   sample_valid        pulse on the last clock of each measure window
//   sample_phase        with sample_valid: 1 = signal, 0 = LO
//   irq, overrun        sticky cycle-complete flag and its overrun flag
module az_sequencer
  import dmm_defs::*;
#(
  parameter int NUM_BITS = 14,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [3:0]          azmux_sig,
  input  logic [3:0]          azmux_lo,
  input  logic [3:0]          himux_cfg,
  input  logic [3:0]          himux2_cfg,
  input  logic [CNT_W-1:0]    t_settle,
  input  logic [CNT_W-1:0]    t_meas,
  input  logic                irq_clear,
  output logic [NUM_BITS-1:0] conditioning_out,
  output logic                adc_window,
  output logic                sample_valid,
  output logic                sample_phase,
  output logic                irq,
  output logic                overrun
);

  state_e           state, state_next;
  logic [1:0]       sh_mode;
  logic [3:0]       sh_az_sig, sh_az_lo, sh_hi, sh_hi2;
  logic [CNT_W-1:0] sh_t_settle, sh_t_meas;
  logic [3:0]       eff_az_sig, eff_hi, eff_hi2;
  logic [CNT_W-1:0] eff_t_settle;
  logic [CNT_W-1:0] count, load_val;
  logic             load, timer_done;
  logic             run_ok, cycle_start, cycle_complete, next_zero, sv_next;
  logic [NUM_BITS-1:0] cond_q;

  // A phase of length t lasts max(t,1) clocks, so the timer loads t-1.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - CNT_W'(1);
  endfunction

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .done     (timer_done)
  );

  // Next-state and timer control. Enable/mode-off are checked live so an
  // abort happens on the next edge; the HI->SETTLE_LO vs wrap decision uses
  // the shadowed mode so a 1<->2 change waits for the next cycle start.
  // At cycle start the shadows are being loaded on this same edge, so the
  // values used for that edge come straight from the inputs.
  always_comb begin
    run_ok     = enable && mode_runs(mode);
    state_next = state;
    case (state)
      IDLE:      if (run_ok) state_next = SETTLE_HI;
      SETTLE_HI: if (timer_done) state_next = MEAS_HI;
      MEAS_HI:   if (timer_done) state_next = (sh_mode == MODE_SIG) ? SETTLE_HI : SETTLE_LO;
      SETTLE_LO: if (timer_done) state_next = MEAS_LO;
      MEAS_LO:   if (timer_done) state_next = SETTLE_HI;
      default:   state_next = IDLE;
    endcase
    if (state != IDLE && !run_ok) state_next = IDLE;

    cycle_start    = (state_next == SETTLE_HI) && (state != SETTLE_HI);
    cycle_complete = (state_next == SETTLE_HI) && (state == MEAS_HI || state == MEAS_LO);

    eff_az_sig   = cycle_start ? azmux_sig  : sh_az_sig;
    eff_hi       = cycle_start ? himux_cfg  : sh_hi;
    eff_hi2      = cycle_start ? himux2_cfg : sh_hi2;
    eff_t_settle = cycle_start ? t_settle   : sh_t_settle;

    load = (state_next != state);
    case (state_next)
      SETTLE_HI, SETTLE_LO: load_val = len_m1(eff_t_settle);
      MEAS_HI, MEAS_LO:     load_val = len_m1(sh_t_meas);
      default:              load_val = '0;
    endcase

    // sample_valid is registered, so it is raised on the edge that brings
    // the timer to zero inside a measure state.
    next_zero = load ? (load_val == '0) : (count <= CNT_W'(1));
    sv_next   = (state_next == MEAS_HI || state_next == MEAS_LO) && next_zero;
  end

  // State, shadow and output registers. Every output is computed from the
  // state being entered so it changes on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      sh_mode      <= '0;
      sh_az_sig    <= '0;
      sh_az_lo     <= '0;
      sh_hi        <= '0;
      sh_hi2       <= '0;
      sh_t_settle  <= '0;
      sh_t_meas    <= '0;
      cond_q       <= '0;
      adc_window   <= 1'b0;
      sample_valid <= 1'b0;
      sample_phase <= 1'b0;
      irq          <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_next;
      adc_window   <= (state_next == MEAS_HI) || (state_next == MEAS_LO);
      sample_valid <= sv_next;
      sample_phase <= sv_next && (state_next == MEAS_HI);

      if (cycle_start) begin
        sh_mode     <= mode;
        sh_az_sig   <= azmux_sig;
        sh_az_lo    <= azmux_lo;
        sh_hi       <= himux_cfg;
        sh_hi2      <= himux2_cfg;
        sh_t_settle <= t_settle;
        sh_t_meas   <= t_meas;
      end

      // LO states only swap azmux and drop pc; himux/himux2/led are kept.
      case (state_next)
        SETTLE_HI, MEAS_HI: begin
          cond_q[AZMUX_LSB +: MUX_W]  <= eff_az_sig;
          cond_q[HIMUX_LSB +: MUX_W]  <= eff_hi;
          cond_q[HIMUX2_LSB +: MUX_W] <= eff_hi2;
          cond_q[PC_BIT]              <= 1'b1;
        end
        SETTLE_LO, MEAS_LO: begin
          cond_q[AZMUX_LSB +: MUX_W] <= sh_az_lo;
          cond_q[PC_BIT]             <= 1'b0;
        end
        default: cond_q <= {NUM_BITS{1'b0}} | NUM_BITS'(MUX_OFF);
      endcase

      // A completed cycle sets irq even against a simultaneous clear; the
      // clear then leaves overrun alone rather than setting it.
      if (cycle_complete) begin
        cond_q[LED_BIT] <= ~cond_q[LED_BIT];
        irq             <= 1'b1;
        if (!irq_clear) overrun <= overrun | irq;
      end else if (irq_clear) begin
        irq     <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

  assign conditioning_out = cond_q;

endmodule

// File: tb/tb_az_sequencer.sv
// tb_az_sequencer - self-checking bench for az_sequencer.
//
// A table of per-clock vectors covers the first two-phase cycle; hand-written
// sequences cover overrun, irq_clear collisions, shadowed t_meas, aborts,
// the signal-only minimum loop and asynchronous reset.
module tb_az_sequencer;
  import dmm_defs::*;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset, enable, irq_clear;
  logic [1:0]       mode;
  logic [3:0]       azmux_sig, azmux_lo, himux_cfg, himux2_cfg;
  logic [CNT_W-1:0] t_settle, t_meas;
  logic [13:0]      conditioning_out;
  logic             adc_window, sample_valid, sample_phase, irq, overrun;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int sv_times[$];
  int sv_phases[$];

  typedef struct {
    logic        enable;
    logic [1:0]  mode;
    logic        irq_clear;
    logic [13:0] cond;
    logic        adc;
    logic        sv;
    logic        phase;
    logic        irq;
    logic        ovr;
  } vec_t;

  vec_t vecs[$];

  az_sequencer #(.NUM_BITS(14), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .mode             (mode),
    .azmux_sig        (azmux_sig),
    .azmux_lo         (azmux_lo),
    .himux_cfg        (himux_cfg),
    .himux2_cfg       (himux2_cfg),
    .t_settle         (t_settle),
    .t_meas           (t_meas),
    .irq_clear        (irq_clear),
    .conditioning_out (conditioning_out),
    .adc_window       (adc_window),
    .sample_valid     (sample_valid),
    .sample_phase     (sample_phase),
    .irq              (irq),
    .overrun          (overrun)
  );

  // 20 MHz system clock.
  always #25 clk = ~clk;

  // Hard stop in case the sequence never completes.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    enable    = v.enable;
    mode      = v.mode;
    irq_clear = v.irq_clear;
  endtask

  // One clock: edge, then sample on the falling edge and log any pulse.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (sample_valid === 1'b1) begin
      sv_times.push_back(cyc);
      sv_phases.push_back(int'(sample_phase));
    end
  endtask

  task automatic tickTo(input int target);
    while (cyc < target) tick();
  endtask

  task automatic addVec(input int c);
    vec_t v;
    v.enable    = 1'b1;
    v.mode      = 2'd2;
    v.irq_clear = 1'b0;
    v.cond      = (c <= 8) ? 14'h1898 : (c <= 16) ? 14'h089B : 14'h3898;
    v.adc       = (c >= 4 && c <= 8) || (c >= 12 && c <= 16);
    v.sv        = (c == 8) || (c == 16);
    v.phase     = (c == 8);
    v.irq       = (c == 17);
    v.ovr       = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic checkSv(input int idx, input int t, input int ph);
    if (sv_times.size() > idx) begin
      checkOutput($sformatf("sv_time%0d", idx), 32'(sv_times[idx]), 32'(t));
      checkOutput($sformatf("sv_phase%0d", idx), 32'(sv_phases[idx]), 32'(ph));
    end else begin
      checkOutput($sformatf("sv_missing%0d", idx), 32'(sv_times.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    // Two-phase cycle: settle 3, measure 5 -> 16 clocks per cycle.
    for (int c = 1; c <= 17; c++) addVec(c);

    reset      = 1'b1;
    enable     = 1'b0;
    mode       = 2'd0;
    irq_clear  = 1'b0;
    azmux_sig  = MUX_S1;
    azmux_lo   = MUX_S4;
    himux_cfg  = MUX_S2;
    himux2_cfg = MUX_S1;
    t_settle   = 32'd3;
    t_meas     = 32'd5;

    repeat (2) @(negedge clk);
    checkOutput("reset_cond", 32'(conditioning_out), 32'h0);
    checkOutput("reset_adc", 32'(adc_window), 32'h0);
    checkOutput("reset_sv", 32'(sample_valid), 32'h0);
    checkOutput("reset_irq", 32'(irq), 32'h0);
    checkOutput("reset_ovr", 32'(overrun), 32'h0);
    reset = 1'b0;
    tick();
    tick();
    checkOutput("idle_cond", 32'(conditioning_out), 32'h0);

    // First full cycle, clock by clock.
    cyc = 0;
    sv_times.delete();
    sv_phases.delete();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("row%0d_cond", i + 1), 32'(conditioning_out), 32'(vecs[i].cond));
      checkOutput($sformatf("row%0d_adc", i + 1), 32'(adc_window), 32'(vecs[i].adc));
      checkOutput($sformatf("row%0d_sv", i + 1), 32'(sample_valid), 32'(vecs[i].sv));
      checkOutput($sformatf("row%0d_phase", i + 1), 32'(sample_phase), 32'(vecs[i].phase));
      checkOutput($sformatf("row%0d_irq", i + 1), 32'(irq), 32'(vecs[i].irq));
      checkOutput($sformatf("row%0d_ovr", i + 1), 32'(overrun), 32'(vecs[i].ovr));
    end

    // Second cycle completes with irq still set -> overrun, led back to 0.
    tickTo(33);
    checkOutput("ovr_irq", 32'(irq), 32'h1);
    checkOutput("ovr_set", 32'(overrun), 32'h1);
    checkOutput("ovr_cond", 32'(conditioning_out), 32'h1898);

    // Third cycle: t_meas raised mid MEAS_HI, clear collides with completion.
    tickTo(37);
    t_meas = 32'd9;
    tickTo(48);
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    checkOutput("coll_irq", 32'(irq), 32'h1);
    checkOutput("coll_ovr", 32'(overrun), 32'h1);
    checkOutput("coll_cond", 32'(conditioning_out), 32'h3898);

    // Fourth cycle uses t_meas=9; enable drops inside SETTLE_LO.
    tickTo(62);
    checkOutput("slo_cond", 32'(conditioning_out), 32'h289B);
    enable = 1'b0;
    tick();
    checkOutput("abort_cond", 32'(conditioning_out), 32'h0);
    checkOutput("abort_adc", 32'(adc_window), 32'h0);
    checkOutput("abort_irq", 32'(irq), 32'h1);
    checkOutput("abort_ovr", 32'(overrun), 32'h1);
    repeat (20) tick();
    checkOutput("sv_count", 32'(sv_times.size()), 32'd7);
    checkSv(0, 8, 1);
    checkSv(1, 16, 0);
    checkSv(2, 24, 1);
    checkSv(3, 32, 0);
    checkSv(4, 40, 1);
    checkSv(5, 48, 0);
    checkSv(6, 60, 1);

    // A lone clear drops both sticky flags.
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    checkOutput("clr_irq", 32'(irq), 32'h0);
    checkOutput("clr_ovr", 32'(overrun), 32'h0);

    // Signal-only mode with zero lengths: two-clock loop.
    t_settle = 32'd0;
    t_meas   = 32'd0;
    mode     = 2'd1;
    enable   = 1'b1;
    cyc      = 0;
    sv_times.delete();
    sv_phases.delete();
    tick();
    checkOutput("m1_c1_cond", 32'(conditioning_out), 32'h1898);
    checkOutput("m1_c1_sv", 32'(sample_valid), 32'h0);
    tick();
    checkOutput("m1_c2_adc", 32'(adc_window), 32'h1);
    checkOutput("m1_c2_sv", 32'(sample_valid), 32'h1);
    checkOutput("m1_c2_phase", 32'(sample_phase), 32'h1);
    checkOutput("m1_c2_irq", 32'(irq), 32'h0);
    tick();
    checkOutput("m1_c3_irq", 32'(irq), 32'h1);
    checkOutput("m1_c3_cond", 32'(conditioning_out), 32'h3898);
    tickTo(10);
    checkOutput("m1_sv_count", 32'(sv_times.size()), 32'd5);
    checkSv(4, 10, 1);

    // Reserved mode mid-sequence aborts; irq is held.
    mode = 2'd3;
    tick();
    checkOutput("m3_cond", 32'(conditioning_out), 32'h0);
    checkOutput("m3_irq", 32'(irq), 32'h1);

    // Asynchronous reset in MEAS_HI clears everything before the next edge.
    mode     = 2'd2;
    t_settle = 32'd3;
    t_meas   = 32'd5;
    cyc      = 0;
    tickTo(5);
    checkOutput("pre_rst_adc", 32'(adc_window), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("rst_cond", 32'(conditioning_out), 32'h0);
    checkOutput("rst_irq", 32'(irq), 32'h0);
    checkOutput("rst_adc", 32'(adc_window), 32'h0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();
    checkOutput("post_rst_cond", 32'(conditioning_out), 32'h0);
    checkOutput("post_rst_adc", 32'(adc_window), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
